peripheral_gpio_apb4: RTL and testbench

APB4 slave exposing a memory-mapped GPIO register bank with input synchronisation, edge and level triggers, and a single interrupt output. The APB4 master bus functional model drives this block in the GPIO bench, and a CPU APB bridge drives it in the MPSoC. It has zero wait states, byte-strobe writes, and error responses for illegal accesses.

---
 rtl/peripheral_gpio_apb4_pkg.sv | 21 ++
 rtl/peripheral_gpio_apb4_if.sv | 25 ++
 rtl/peripheral_gpio_synchronizer.sv | 19 +
 rtl/peripheral_gpio_apb4.sv | 134 +++++++++++++
 tb/tb_peripheral_gpio_apb4.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/peripheral_gpio_apb4_pkg.sv
// Shared register map and field encodings for the APB4 GPIO block.
package peripheral_gpio_apb4_pkg;

  localparam logic [5:0] REG_MODE        = 6'h00;
  localparam logic [5:0] REG_DIRECTION   = 6'h04;
  localparam logic [5:0] REG_OUTPUT      = 6'h08;
  localparam logic [5:0] REG_INPUT       = 6'h0C;
  localparam logic [5:0] REG_TRIG_TYPE   = 6'h10;
  localparam logic [5:0] REG_TRIG_LVL0   = 6'h14;
  localparam logic [5:0] REG_TRIG_LVL1   = 6'h18;
  localparam logic [5:0] REG_TRIG_STATUS = 6'h1C;
  localparam logic [5:0] REG_IRQ_ENA     = 6'h20;

  localparam logic [5:0] MAX_OFFSET = REG_IRQ_ENA;

  localparam logic MODE_PUSHPULL  = 1'b0;
  localparam logic MODE_OPENDRAIN = 1'b1;
  localparam logic TRIG_LEVEL     = 1'b0;
  localparam logic TRIG_EDGE      = 1'b1;

endpackage

// File: rtl/peripheral_gpio_apb4_if.sv
// APB4 bus bundle between master (BFM / bridge) and the GPIO slave.
interface peripheral_gpio_apb4_if #(
  parameter int PADDR_SIZE = 16,
  parameter int PDATA_SIZE = 32
);
  logic                    PSEL;
  logic                    PENABLE;
  logic [PADDR_SIZE-1:0]   PADDR;
  logic                    PWRITE;
  logic [PDATA_SIZE/8-1:0] PSTRB;
  logic [PDATA_SIZE-1:0]   PWDATA;
  logic [PDATA_SIZE-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    output PSEL, PENABLE, PADDR, PWRITE, PSTRB, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PADDR, PWRITE, PSTRB, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/peripheral_gpio_synchronizer.sv
// Multi-flop synchroniser for asynchronous pad inputs; last stage is the output.
module peripheral_gpio_synchronizer #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [DEPTH-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stage_q <= '0;
    else         stage_q <= {stage_q[DEPTH-2:0], d_i};
  end

  assign q_o = stage_q[DEPTH-1];
endmodule

// File: rtl/peripheral_gpio_apb4.sv
// APB4 GPIO slave: register bank, pad drive, edge/level triggers and one IRQ.
module peripheral_gpio_apb4
  import peripheral_gpio_apb4_pkg::*;
#(
  parameter int PADDR_SIZE   = 16,
  parameter int PDATA_SIZE   = 32,
  parameter int INPUT_STAGES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  peripheral_gpio_apb4_if.slave apb,
  input  logic [PDATA_SIZE-1:0] gpio_i,
  output logic [PDATA_SIZE-1:0] gpio_o,
  output logic [PDATA_SIZE-1:0] gpio_oe,
  output logic                  irq_o
);
  localparam int W  = PDATA_SIZE;
  localparam int NB = PDATA_SIZE / 8;

  logic [5:0]   off;
  logic         access, setup_rd, err, wr;
  logic [W-1:0] bmask, clr, trig_set, in_w;
  logic         unused_addr;

  logic [W-1:0] mode_q, dir_q, out_q, ttype_q, lvl0_q, lvl1_q, stat_q, ena_q, prev_q, rdata_q;
  logic [W-1:0] mode_d, dir_d, out_d, ttype_d, lvl0_d, lvl1_d, stat_d, ena_d, rdata_d;
  logic         irq_q, irq_d;

  function automatic logic [W-1:0] wmerge(logic [W-1:0] old, logic [W-1:0] wd, logic [W-1:0] m);
    return (old & ~m) | (wd & m);
  endfunction

  assign off         = {apb.PADDR[5:2], 2'b00};
  assign unused_addr = ^{apb.PADDR[PADDR_SIZE-1:6], apb.PADDR[1:0]};
  assign access      = apb.PSEL & apb.PENABLE;
  assign setup_rd    = apb.PSEL & ~apb.PENABLE & ~apb.PWRITE;
  assign err         = access & ((off > MAX_OFFSET) | (apb.PWRITE & (off == REG_INPUT)));
  assign wr          = access & apb.PWRITE & ~err;
  assign apb.PSLVERR = err;
  assign apb.PREADY  = 1'b1;
  assign apb.PRDATA  = rdata_q;
  assign irq_o       = irq_q;

  always_comb begin
    bmask = '0;
    for (int k = 0; k < NB; k++) bmask[8*k +: 8] = {8{apb.PSTRB[k]}};
  end

  peripheral_gpio_synchronizer #(.DEPTH(INPUT_STAGES), .WIDTH(W)) u_sync (
    .clk_i (PCLK),
    .rst_ni(PRESETn),
    .d_i   (gpio_i),
    .q_o   (in_w)
  );

  // Per-pin pad drive and trigger selection
  for (genvar i = 0; i < W; i++) begin : g_pin
    assign gpio_o[i]   = (mode_q[i] == MODE_OPENDRAIN) ? 1'b0 : out_q[i];
    assign gpio_oe[i]  = (mode_q[i] == MODE_OPENDRAIN) ? (dir_q[i] & ~out_q[i]) : dir_q[i];
    assign trig_set[i] = (ttype_q[i] == TRIG_EDGE)
                       ? ((lvl1_q[i] & in_w[i] & ~prev_q[i]) | (lvl0_q[i] & ~in_w[i] & prev_q[i]))
                       : ((lvl1_q[i] & in_w[i]) | (lvl0_q[i] & ~in_w[i]));
  end

  always_comb begin
    mode_d  = mode_q;
    dir_d   = dir_q;
    out_d   = out_q;
    ttype_d = ttype_q;
    lvl0_d  = lvl0_q;
    lvl1_d  = lvl1_q;
    ena_d   = ena_q;
    clr     = '0;
    rdata_d = rdata_q;
    if (wr) begin
      case (off)
        REG_MODE:        mode_d  = wmerge(mode_q,  apb.PWDATA, bmask);
        REG_DIRECTION:   dir_d   = wmerge(dir_q,   apb.PWDATA, bmask);
        REG_OUTPUT:      out_d   = wmerge(out_q,   apb.PWDATA, bmask);
        REG_TRIG_TYPE:   ttype_d = wmerge(ttype_q, apb.PWDATA, bmask);
        REG_TRIG_LVL0:   lvl0_d  = wmerge(lvl0_q,  apb.PWDATA, bmask);
        REG_TRIG_LVL1:   lvl1_d  = wmerge(lvl1_q,  apb.PWDATA, bmask);
        REG_TRIG_STATUS: clr     = apb.PWDATA & bmask;
        REG_IRQ_ENA:     ena_d   = wmerge(ena_q,   apb.PWDATA, bmask);
        default: ;
      endcase
    end
    // New trigger hits win over a same-cycle software clear
    stat_d = (stat_q & ~clr) | trig_set;
    irq_d  = |(stat_q & ena_q);
    if (setup_rd) begin
      case (off)
        REG_MODE:        rdata_d = mode_q;
        REG_DIRECTION:   rdata_d = dir_q;
        REG_OUTPUT:      rdata_d = out_q;
        REG_INPUT:       rdata_d = in_w;
        REG_TRIG_TYPE:   rdata_d = ttype_q;
        REG_TRIG_LVL0:   rdata_d = lvl0_q;
        REG_TRIG_LVL1:   rdata_d = lvl1_q;
        REG_TRIG_STATUS: rdata_d = stat_q;
        REG_IRQ_ENA:     rdata_d = ena_q;
        default:         rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      mode_q  <= '0;
      dir_q   <= '0;
      out_q   <= '0;
      ttype_q <= '0;
      lvl0_q  <= '0;
      lvl1_q  <= '0;
      stat_q  <= '0;
      ena_q   <= '0;
      prev_q  <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      out_q   <= out_d;
      ttype_q <= ttype_d;
      lvl0_q  <= lvl0_d;
      lvl1_q  <= lvl1_d;
      stat_q  <= stat_d;
      ena_q   <= ena_d;
      prev_q  <= in_w;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end
endmodule

// File: tb/tb_peripheral_gpio_apb4.sv
// Directed bench for the APB4 GPIO slave with a queue of expected responses.
module tb_peripheral_gpio_apb4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int ST = 2;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic [DW-1:0] gpio_i, gpio_o, gpio_oe;
  logic          irq_o;

  peripheral_gpio_apb4_if #(.PADDR_SIZE(AW), .PDATA_SIZE(DW)) apb ();

  peripheral_gpio_apb4 #(.PADDR_SIZE(AW), .PDATA_SIZE(DW), .INPUT_STAGES(ST)) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .apb    (apb),
    .gpio_i (gpio_i),
    .gpio_o (gpio_o),
    .gpio_oe(gpio_oe),
    .irq_o  (irq_o)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expectation is queued when the transfer is launched and retired in its access phase
  task automatic xfer(input logic w, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [31:0] exp_d, input logic exp_e, input string tag);
    exp_t e;
    e.tag = tag; e.data = exp_d; e.err = exp_e;
    sb.push_back(e);
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PADDR = a; apb.PWRITE = w; apb.PWDATA = d; apb.PSTRB = s;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    #2;
    e = sb.pop_front();
    chk({e.tag, ".err"}, 64'(apb.PSLVERR), 64'(e.err));
    if (!w) chk({e.tag, ".data"}, 64'(apb.PRDATA), 64'(e.data));
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s, input string tag);
    xfer(1'b1, a, d, s, 32'h0, 1'b0, tag);
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] exp_d, input string tag);
    xfer(1'b0, a, 32'h0, 4'h0, exp_d, 1'b0, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PADDR = '0; apb.PWRITE = 1'b0;
    apb.PSTRB = '0; apb.PWDATA = '0;
    gpio_i = '0;
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_irq", 64'(irq_o), 64'd0);
    chk("rst_oe", 64'(gpio_oe), 64'd0);
    chk("rst_o", 64'(gpio_o), 64'd0);
    chk("rst_pready", 64'(apb.PREADY), 64'd1);
    chk("rst_pslverr", 64'(apb.PSLVERR), 64'd0);
    PRESETn = 1'b1;

    for (int i = 0; i < 9; i++) rd(16'(i * 4), 32'h0, $sformatf("rst_rd%0d", i));

    wr(16'h04, 32'hFFFF_FFFF, 4'b0101, "dir_wr");
    rd(16'h04, 32'h00FF_00FF, "dir_strb");
    wr(16'h08, 32'h0000_00A5, 4'hF, "out_wr");
    chk("pp_o", 64'(gpio_o), 64'h0000_00A5);
    chk("pp_oe", 64'(gpio_oe), 64'h00FF_00FF);

    wr(16'h00, 32'h1, 4'hF, "od_mode");
    wr(16'h04, 32'h1, 4'hF, "od_dir");
    wr(16'h08, 32'h0, 4'hF, "od_out0");
    chk("od_o_low", 64'(gpio_o), 64'h0);
    chk("od_oe_low", 64'(gpio_oe), 64'h1);
    wr(16'h08, 32'h1, 4'hF, "od_out1");
    chk("od_o_rel", 64'(gpio_o), 64'h0);
    chk("od_oe_rel", 64'(gpio_oe), 64'h0);
    wr(16'h00, 32'h0, 4'hF, "clr_mode");
    wr(16'h04, 32'h0, 4'hF, "clr_dir");
    wr(16'h08, 32'h0, 4'hF, "clr_out");

    wr(16'h10, 32'h1, 4'hF, "edge_type");
    wr(16'h18, 32'h1, 4'hF, "edge_lvl1");
    wr(16'h20, 32'h1, 4'hF, "edge_ena");
    @(posedge PCLK); #1;
    gpio_i[0] = 1'b1;
    repeat (ST + 1) @(posedge PCLK);
    #1;
    chk("edge_irq_early", 64'(irq_o), 64'd0);
    @(posedge PCLK); #1;
    chk("edge_irq", 64'(irq_o), 64'd1);
    rd(16'h1C, 32'h1, "edge_stat");
    wr(16'h1C, 32'h1, 4'hF, "w1c");
    chk("w1c_irq_hold", 64'(irq_o), 64'd1);
    @(posedge PCLK); #1;
    chk("w1c_irq_drop", 64'(irq_o), 64'd0);
    rd(16'h1C, 32'h0, "w1c_stat");

    wr(16'h10, 32'h0, 4'hF, "lvl_type");
    repeat (2) @(posedge PCLK);
    #1;
    chk("lvl_irq", 64'(irq_o), 64'd1);
    wr(16'h1C, 32'h1, 4'hF, "collide_w1c");
    rd(16'h1C, 32'h1, "collide_stat");
    chk("collide_irq", 64'(irq_o), 64'd1);
    wr(16'h18, 32'h0, 4'hF, "lvl_off");
    wr(16'h1C, 32'h1, 4'hF, "lvl_w1c");
    repeat (2) @(posedge PCLK);
    #1;
    chk("lvl_off_irq", 64'(irq_o), 64'd0);

    xfer(1'b1, 16'h0C, 32'hFFFF_FFFE, 4'hF, 32'h0, 1'b1, "wr_input");
    rd(16'h0C, 32'h1, "input_kept");
    xfer(1'b0, 16'h24, 32'h0, 4'h0, 32'h0, 1'b1, "rd_oor24");
    xfer(1'b0, 16'h3C, 32'h0, 4'h0, 32'h0, 1'b1, "rd_oor3c");

    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PADDR = 16'h08; apb.PWRITE = 1'b1;
    apb.PWDATA = 32'hDEAD_BEEF; apb.PSTRB = 4'hF;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    #2;
    PRESETn = 1'b0;
    #1;
    chk("abort_o_in_rst", 64'(gpio_o), 64'h0);
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    rd(16'h08, 32'h0, "abort_out");
    chk("abort_o", 64'(gpio_o), 64'h0);
    repeat (5) @(posedge PCLK);
    rd(16'h1C, 32'h0, "hi_at_rst_stat");
    chk("hi_at_rst_irq", 64'(irq_o), 64'd0);
    rd(16'h0C, 32'h1, "input_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
